// File: rtl/sparc_exu_pkg.sv
// Shared widths and helpers for the sparc_exu execute-stage datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sparc_exu_pkg;

  localparam int EXU_W   = 64;
  localparam int SHAMT_W = 6;

  typedef logic [EXU_W-1:0] word_t;

  // Index of a one-hot 4-bit select; with several bits set the indices OR together,
  // and a zero-hot vector maps to 0.
  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

  // Logical right shift that fills the vacated upper bits with 'fill'.
  function automatic word_t shr_fill(input word_t x, input logic [SHAMT_W-1:0] n, input logic fill);
    logic [2*EXU_W-1:0] t;
    t = {{EXU_W{fill}}, x} >> n;
    return t[EXU_W-1:0];
  endfunction

endpackage

// File: rtl/sparc_exu_if.sv
// Operand, control and result bundle between the E-stage controls and sparc_exu.
// Latency: n/a (wires only).
// Backpressure: none; every field is sampled combinationally each cycle.
interface sparc_exu_if;
  import sparc_exu_pkg::*;

  word_t      byp_alu_rs1_data_e;
  word_t      byp_alu_rs2_data_e;
  logic       ecl_alu_cin_e;
  logic       ifu_exu_invert_d;
  logic       ecl_alu_log_sel_and_e;
  logic       ecl_alu_log_sel_or_e;
  logic       ecl_alu_log_sel_xor_e;
  logic       ecl_alu_log_sel_move_e;
  logic       ecl_alu_out_sel_sum_e_l;
  logic       ecl_alu_out_sel_shift_e_l;
  logic       ecl_alu_out_sel_logic_e_l;
  logic       ecl_alu_sethi_inst_e;
  logic       ecl_shft_op32_e;
  logic [3:0] ecl_shft_shift4_e;
  logic [3:0] ecl_shft_shift1_e;
  logic       ecl_shft_enshift_e_l;
  logic       ecl_shft_extendbit_e;
  logic       ecl_shft_extend32bit_e_l;
  logic       ecl_shft_lshift_e_l;
  word_t      alu_byp_rd_data_e;

  modport master (
    output byp_alu_rs1_data_e, byp_alu_rs2_data_e, ecl_alu_cin_e, ifu_exu_invert_d,
           ecl_alu_log_sel_and_e, ecl_alu_log_sel_or_e, ecl_alu_log_sel_xor_e,
           ecl_alu_log_sel_move_e, ecl_alu_out_sel_sum_e_l, ecl_alu_out_sel_shift_e_l,
           ecl_alu_out_sel_logic_e_l, ecl_alu_sethi_inst_e, ecl_shft_op32_e,
           ecl_shft_shift4_e, ecl_shft_shift1_e, ecl_shft_enshift_e_l,
           ecl_shft_extendbit_e, ecl_shft_extend32bit_e_l, ecl_shft_lshift_e_l,
    input  alu_byp_rd_data_e
  );

  modport slave (
    input  byp_alu_rs1_data_e, byp_alu_rs2_data_e, ecl_alu_cin_e, ifu_exu_invert_d,
           ecl_alu_log_sel_and_e, ecl_alu_log_sel_or_e, ecl_alu_log_sel_xor_e,
           ecl_alu_log_sel_move_e, ecl_alu_out_sel_sum_e_l, ecl_alu_out_sel_shift_e_l,
           ecl_alu_out_sel_logic_e_l, ecl_alu_sethi_inst_e, ecl_shft_op32_e,
           ecl_shft_shift4_e, ecl_shft_shift1_e, ecl_shft_enshift_e_l,
           ecl_shft_extendbit_e, ecl_shft_extend32bit_e_l, ecl_shft_lshift_e_l,
    output alu_byp_rd_data_e
  );

endinterface

// File: rtl/sparc_exu_shft.sv
// Barrel shifter: 16/4/1 stages, left zero-fill or right with extend fill, op32 and upper-word extend.
// Latency: combinational.
// Backpressure: none.
module sparc_exu_shft
  import sparc_exu_pkg::*;
(
  input  word_t      rs1,
  input  logic [1:0] rs2_cnt_hi,      // rs2[5:4], the shift-by-16 count
  input  logic       op32,
  input  logic [3:0] shift4,
  input  logic [3:0] shift1,
  input  logic       enshift_l,
  input  logic       extendbit,
  input  logic       extend32bit_l,
  input  logic       lshift_l,
  output word_t      shift_out
);

  logic [1:0] amt16, amt4, amt1;
  word_t      r_opnd;
  word_t      l16, l4, l1;
  word_t      r16, r4, r1;
  word_t      shifted;

  // decode the three stage counts; a 32-bit op caps the 16-stage at one step
  always_comb begin
    amt16 = {rs2_cnt_hi[1] & ~op32, rs2_cnt_hi[0]};
    amt4  = onehot_idx(shift4);
    amt1  = onehot_idx(shift1);
  end

  // left path: plain zero-fill on the full 64-bit rs1
  always_comb begin
    l16 = rs1 << {amt16, 4'b0000};
    l4  = l16 << {2'b00, amt4, 2'b00};
    l1  = l4  << {4'b0000, amt1};
  end

  // right path: a 32-bit op sees the low word under an extend-bit upper word
  always_comb begin
    r_opnd = op32 ? {{32{extendbit}}, rs1[31:0]} : rs1;
    r16    = shr_fill(r_opnd, {amt16, 4'b0000}, extendbit);
    r4     = shr_fill(r16, {2'b00, amt4, 2'b00}, extendbit);
    r1     = shr_fill(r4, {4'b0000, amt1}, extendbit);
  end

  // pick direction, apply upper-word extension, then gate by the enable
  always_comb begin
    shifted = lshift_l ? r1 : l1;
    if (!extend32bit_l) begin
      shifted[63:32] = {32{extendbit}};
    end
    shift_out = enshift_l ? '0 : shifted;
  end

endmodule

// File: rtl/sparc_exu.sv
// E-stage integer datapath: adder, logic unit, SETHI move and shifter behind an active-low OR mux.
// Latency: combinational from E inputs; the rs2 invert request is taken in D and used one cycle later.
// Backpressure: none; a result is produced every cycle.
module sparc_exu
  import sparc_exu_pkg::*;
(
  input  logic         rclk,
  input  logic         reset,
  sparc_exu_if.slave   exu
);

  logic  invert_e;
  word_t op_a, op_b;
  word_t sum_e, logic_e, shift_e;

  // carry the D-stage invert request into E
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      invert_e <= 1'b0;
    end else begin
      invert_e <= exu.ifu_exu_invert_d;
    end
  end

  // SETHI clears rs1 so the move path and the adder both see rs2 alone
  always_comb begin
    op_a = exu.ecl_alu_sethi_inst_e ? '0 : exu.byp_alu_rs1_data_e;
    op_b = invert_e ? ~exu.byp_alu_rs2_data_e : exu.byp_alu_rs2_data_e;
  end

  // 64-bit add with carry-in; carry-out is not needed downstream
  always_comb begin
    sum_e = op_a + op_b + {{(EXU_W-1){1'b0}}, exu.ecl_alu_cin_e};
  end

  // logic unit: OR of whichever terms are selected
  always_comb begin
    logic_e = '0;
    if (exu.ecl_alu_log_sel_and_e)  logic_e = logic_e | (op_a & op_b);
    if (exu.ecl_alu_log_sel_or_e)   logic_e = logic_e | (op_a | op_b);
    if (exu.ecl_alu_log_sel_xor_e)  logic_e = logic_e | (op_a ^ op_b);
    if (exu.ecl_alu_log_sel_move_e) logic_e = logic_e | op_b;
  end

  // the shifter works on raw rs1/rs2, never on the inverted operand
  sparc_exu_shft u_shft (
    .rs1           (exu.byp_alu_rs1_data_e),
    .rs2_cnt_hi    (exu.byp_alu_rs2_data_e[5:4]),
    .op32          (exu.ecl_shft_op32_e),
    .shift4        (exu.ecl_shft_shift4_e),
    .shift1        (exu.ecl_shft_shift1_e),
    .enshift_l     (exu.ecl_shft_enshift_e_l),
    .extendbit     (exu.ecl_shft_extendbit_e),
    .extend32bit_l (exu.ecl_shft_extend32bit_e_l),
    .lshift_l      (exu.ecl_shft_lshift_e_l),
    .shift_out     (shift_e)
  );

  // active-low OR mux onto the bypass result
  always_comb begin
    exu.alu_byp_rd_data_e = ({EXU_W{~exu.ecl_alu_out_sel_sum_e_l}}   & sum_e)
                          | ({EXU_W{~exu.ecl_alu_out_sel_shift_e_l}} & shift_e)
                          | ({EXU_W{~exu.ecl_alu_out_sel_logic_e_l}} & logic_e);
  end

endmodule

// File: tb/tb_sparc_exu.sv
// Self-checking bench for sparc_exu: directed literal checks plus randomized cycles against a model.
// Latency: model tracks the one-cycle invert request through its own register.
// Backpressure: n/a.
module tb_sparc_exu;
  import sparc_exu_pkg::*;

  logic rclk;
  logic reset;
  logic chk_en;
  logic m_inv;
  int   n_checks;
  int   n_errors;

  sparc_exu_if bus();

  sparc_exu dut (
    .rclk  (rclk),
    .reset (reset),
    .exu   (bus)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  // model copy of the invert register
  always @(posedge rclk or posedge reset) begin
    if (reset) m_inv <= 1'b0;
    else       m_inv <= bus.ifu_exu_invert_d;
  end

  // reference result computed straight from the operation definitions
  function automatic logic [63:0] model_out(input logic inv);
    logic [63:0] a, b, s, lg, sh, opnd, res;
    int amt, i4, i1;
    a  = bus.ecl_alu_sethi_inst_e ? 64'd0 : bus.byp_alu_rs1_data_e;
    b  = inv ? ~bus.byp_alu_rs2_data_e : bus.byp_alu_rs2_data_e;
    s  = a + b + 64'(bus.ecl_alu_cin_e);
    lg = 64'd0;
    if (bus.ecl_alu_log_sel_and_e)  lg |= a & b;
    if (bus.ecl_alu_log_sel_or_e)   lg |= a | b;
    if (bus.ecl_alu_log_sel_xor_e)  lg |= a ^ b;
    if (bus.ecl_alu_log_sel_move_e) lg |= b;
    if (bus.ecl_shft_op32_e) amt = 16 * int'(bus.byp_alu_rs2_data_e[4]);
    else                     amt = 16 * int'(bus.byp_alu_rs2_data_e[5:4]);
    i4 = 0;
    i1 = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.ecl_shft_shift4_e[i]) i4 |= i;
      if (bus.ecl_shft_shift1_e[i]) i1 |= i;
    end
    amt = amt + 4 * i4 + i1;
    if (!bus.ecl_shft_lshift_e_l) begin
      sh = bus.byp_alu_rs1_data_e << amt;
    end else begin
      opnd = bus.ecl_shft_op32_e ? {{32{bus.ecl_shft_extendbit_e}}, bus.byp_alu_rs1_data_e[31:0]}
                                 : bus.byp_alu_rs1_data_e;
      for (int k = 0; k < 64; k++) begin
        sh[k] = (k + amt < 64) ? opnd[k + amt] : bus.ecl_shft_extendbit_e;
      end
    end
    if (!bus.ecl_shft_extend32bit_e_l) sh[63:32] = {32{bus.ecl_shft_extendbit_e}};
    if (bus.ecl_shft_enshift_e_l) sh = 64'd0;
    res = 64'd0;
    if (!bus.ecl_alu_out_sel_sum_e_l)   res |= s;
    if (!bus.ecl_alu_out_sel_shift_e_l) res |= sh;
    if (!bus.ecl_alu_out_sel_logic_e_l) res |= lg;
    return res;
  endfunction

  // per-cycle comparison of DUT against the model, away from the active edge
  always @(negedge rclk) begin
    if (chk_en) begin
      logic [63:0] exp_v;
      exp_v = model_out(m_inv);
      n_checks++;
      if (bus.alu_byp_rd_data_e !== exp_v) begin
        n_errors++;
        $display("FAIL cycle_cmp t=%0t: got %h expected %h", $time, bus.alu_byp_rd_data_e, exp_v);
      end
    end
  end

  task automatic check_lit(input string name, input logic [63:0] lit);
    logic [63:0] mv;
    n_checks++;
    if (bus.alu_byp_rd_data_e !== lit) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, bus.alu_byp_rd_data_e, lit);
    end
    mv = model_out(m_inv);
    n_checks++;
    if (mv !== lit) begin
      n_errors++;
      $display("FAIL model_%s: model %h expected %h", name, mv, lit);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.byp_alu_rs1_data_e        = '0;
    bus.byp_alu_rs2_data_e        = '0;
    bus.ecl_alu_cin_e             = 1'b0;
    bus.ifu_exu_invert_d          = 1'b0;
    bus.ecl_alu_log_sel_and_e     = 1'b0;
    bus.ecl_alu_log_sel_or_e      = 1'b0;
    bus.ecl_alu_log_sel_xor_e     = 1'b0;
    bus.ecl_alu_log_sel_move_e    = 1'b0;
    bus.ecl_alu_out_sel_sum_e_l   = 1'b1;
    bus.ecl_alu_out_sel_shift_e_l = 1'b1;
    bus.ecl_alu_out_sel_logic_e_l = 1'b1;
    bus.ecl_alu_sethi_inst_e      = 1'b0;
    bus.ecl_shft_op32_e           = 1'b0;
    bus.ecl_shft_shift4_e         = 4'b0000;
    bus.ecl_shft_shift1_e         = 4'b0000;
    bus.ecl_shft_enshift_e_l      = 1'b1;
    bus.ecl_shft_extendbit_e      = 1'b0;
    bus.ecl_shft_extend32bit_e_l  = 1'b1;
    bus.ecl_shft_lshift_e_l       = 1'b1;
  endtask

  function automatic logic [3:0] rand_sel4();
    logic [3:0] v;
    if ($urandom_range(0, 3) == 0) v = 4'($urandom_range(0, 15));
    else                           v = 4'b0001 << $urandom_range(0, 3);
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_en   = 1'b0;
    reset    = 1'b0;
    idle_inputs();
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;

    // 1: reset state and plain add
    bus.byp_alu_rs1_data_e      = 64'd5;
    bus.byp_alu_rs2_data_e      = 64'd3;
    bus.ecl_alu_out_sel_sum_e_l = 1'b0;
    bus.ifu_exu_invert_d        = 1'b1;
    #1 check_lit("reset_state", 64'h8);
    tick();
    check_lit("reset_hold", 64'h8);
    reset = 1'b0;
    bus.ifu_exu_invert_d = 1'b0;
    tick();
    check_lit("add", 64'h8);

    // 2: subtract via delayed invert, then async reset clears it
    bus.ifu_exu_invert_d   = 1'b1;
    bus.byp_alu_rs1_data_e = 64'd10;
    bus.ecl_alu_cin_e      = 1'b1;
    #1 check_lit("pre_edge", 64'd14);
    tick();
    check_lit("sub", 64'h7);
    bus.ifu_exu_invert_d = 1'b0;
    reset = 1'b1;
    #1 check_lit("async_reset", 64'd14);
    reset = 1'b0;
    tick();

    // 3: logic ops, with ANDN after the invert lands
    bus.byp_alu_rs1_data_e        = 64'hFF00;
    bus.byp_alu_rs2_data_e        = 64'h0FF0;
    bus.ecl_alu_cin_e             = 1'b0;
    bus.ecl_alu_out_sel_sum_e_l   = 1'b1;
    bus.ecl_alu_out_sel_logic_e_l = 1'b0;
    bus.ecl_alu_log_sel_xor_e     = 1'b1;
    #1 check_lit("xor", 64'hF0F0);
    bus.ifu_exu_invert_d = 1'b1;
    tick();
    bus.ecl_alu_log_sel_xor_e = 1'b0;
    bus.ecl_alu_log_sel_and_e = 1'b1;
    #1 check_lit("andn", 64'hF000);
    bus.ifu_exu_invert_d = 1'b0;
    tick();

    // 4: left shift by 35, then disabled shifter
    bus.ecl_alu_out_sel_logic_e_l = 1'b1;
    bus.ecl_alu_log_sel_and_e     = 1'b0;
    bus.byp_alu_rs1_data_e        = 64'd1;
    bus.byp_alu_rs2_data_e        = 64'h20;
    bus.ecl_shft_shift4_e         = 4'b0001;
    bus.ecl_shft_shift1_e         = 4'b1000;
    bus.ecl_shft_lshift_e_l       = 1'b0;
    bus.ecl_shft_enshift_e_l      = 1'b0;
    bus.ecl_shft_op32_e           = 1'b0;
    bus.ecl_shft_extend32bit_e_l  = 1'b1;
    bus.ecl_alu_out_sel_shift_e_l = 1'b0;
    #1 check_lit("sll35", 64'h0000_0008_0000_0000);
    bus.ecl_shft_enshift_e_l = 1'b1;
    #1 check_lit("shift_off", 64'h0);

    // 5: 32-bit arithmetic right shift by 4
    bus.ecl_shft_enshift_e_l     = 1'b0;
    bus.byp_alu_rs1_data_e       = 64'h8000_0000;
    bus.byp_alu_rs2_data_e       = 64'h0;
    bus.ecl_shft_shift4_e        = 4'b0010;
    bus.ecl_shft_shift1_e        = 4'b0001;
    bus.ecl_shft_op32_e          = 1'b1;
    bus.ecl_shft_extendbit_e     = 1'b1;
    bus.ecl_shft_extend32bit_e_l = 1'b0;
    bus.ecl_shft_lshift_e_l      = 1'b1;
    #1 check_lit("sra32", 64'hFFFF_FFFF_F800_0000);
    tick();

    // 6: SETHI through the logic and adder paths, then no output selected
    idle_inputs();
    bus.ecl_alu_sethi_inst_e      = 1'b1;
    bus.byp_alu_rs1_data_e        = 64'hDEAD;
    bus.byp_alu_rs2_data_e        = 64'h1234_5000;
    bus.ecl_alu_log_sel_or_e      = 1'b1;
    bus.ecl_alu_out_sel_logic_e_l = 1'b0;
    #1 check_lit("sethi_or", 64'h1234_5000);
    bus.ecl_alu_out_sel_logic_e_l = 1'b1;
    bus.ecl_alu_out_sel_sum_e_l   = 1'b0;
    #1 check_lit("sethi_sum", 64'h1234_5000);
    bus.ecl_alu_out_sel_sum_e_l   = 1'b1;
    #1 check_lit("no_select", 64'h0);

    // randomized traffic, with occasional mid-cycle resets
    for (int n = 0; n < 600; n++) begin
      tick();
      reset = ($urandom_range(0, 31) == 0);
      bus.byp_alu_rs1_data_e        = {$urandom, $urandom};
      bus.byp_alu_rs2_data_e        = {$urandom, $urandom};
      bus.ecl_alu_cin_e             = 1'($urandom);
      bus.ifu_exu_invert_d          = 1'($urandom);
      bus.ecl_alu_log_sel_and_e     = 1'($urandom);
      bus.ecl_alu_log_sel_or_e      = 1'($urandom);
      bus.ecl_alu_log_sel_xor_e     = 1'($urandom);
      bus.ecl_alu_log_sel_move_e    = 1'($urandom);
      bus.ecl_alu_out_sel_sum_e_l   = 1'($urandom);
      bus.ecl_alu_out_sel_shift_e_l = 1'($urandom);
      bus.ecl_alu_out_sel_logic_e_l = 1'($urandom);
      bus.ecl_alu_sethi_inst_e      = ($urandom_range(0, 7) == 0);
      bus.ecl_shft_op32_e           = 1'($urandom);
      bus.ecl_shft_shift4_e         = rand_sel4();
      bus.ecl_shft_shift1_e         = rand_sel4();
      bus.ecl_shft_enshift_e_l      = ($urandom_range(0, 7) == 0);
      bus.ecl_shft_extendbit_e      = 1'($urandom);
      bus.ecl_shft_extend32bit_e_l  = 1'($urandom);
      bus.ecl_shft_lshift_e_l       = 1'($urandom);
    end
    tick();
    reset = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
